// File: rtl/audio_pkg.sv
// Shared constants for the audio serial transmitter: wire-format mode codes and
// the bit-clock divider helpers used at elaboration time.
package audio_pkg;

  localparam logic [1:0] MODE_I2S  = 2'd0;
  localparam logic [1:0] MODE_LJ   = 2'd1;
  localparam logic [1:0] MODE_DSP  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  function automatic int unsigned bck_half(input int unsigned ref_clk,
                                           input int unsigned sample_rate,
                                           input int unsigned frame_bits);
    return ref_clk / (sample_rate * frame_bits * 2);
  endfunction

  // True only when the system clock divides into whole BCK half-periods.
  function automatic bit bck_half_exact(input int unsigned ref_clk,
                                        input int unsigned sample_rate,
                                        input int unsigned frame_bits);
    int unsigned den;
    den = sample_rate * frame_bits * 2;
    return (den != 0) && (ref_clk >= den) && ((ref_clk % den) == 0);
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with occupancy count; push is dropped when full and pop
// is ignored when empty. Read data is the head entry, valid while not empty.
module audio_frame_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    level_q;
  logic             push_en, pop_en;

  assign full_o  = (level_q == (PtrW + 1)'(Depth));
  assign empty_o = (level_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
      if (push_en && !pop_en)      level_q <= level_q + 1'b1;
      else if (pop_en && !push_en) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Multi-channel audio serial transmitter (I2S / left-justified / DSP-TDM).
// BCK and LRCK are registered outputs advanced by clock enables on iCLK only.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned REF_CLK         = 18432000,
  parameter int unsigned SAMPLE_RATE     = 48000,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned SLOT_WIDTH      = 16,
  parameter int unsigned CHANNEL_NUM     = 2,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned UNDERRUN_REPEAT = 0
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iDATA,
  input  logic                              iVALID,
  output logic                              oREADY,
  input  logic [1:0]                        iMODE,
  input  logic                              iMUTE,
  output logic                              oAUD_BCK,
  output logic                              oAUD_LRCK,
  output logic                              oAUD_DATA,
  output logic                              oUNDERRUN,
  output logic [$clog2(FIFO_DEPTH):0]       oFIFO_LEVEL
);

  localparam int unsigned FRAME_BITS = CHANNEL_NUM * SLOT_WIDTH;
  localparam int unsigned FRAME_W    = DATA_WIDTH * CHANNEL_NUM;
  localparam int unsigned BCK_HALF   = bck_half(REF_CLK, SAMPLE_RATE, FRAME_BITS);
  localparam int unsigned DivW       = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int unsigned BitW       = $clog2(FRAME_BITS);

  if (!bck_half_exact(REF_CLK, SAMPLE_RATE, FRAME_BITS)) begin : g_bad_ratio
    $error("REF_CLK is not a whole multiple of 2*SAMPLE_RATE*FRAME_BITS");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH > 32 || SLOT_WIDTH < DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be 8..32 and no wider than SLOT_WIDTH");
  end

  logic [DivW-1:0]       div_q, div_d;
  logic                  bck_q, bck_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [1:0]            mode_q, mode_d;
  logic                  lrck_q, lrck_d;
  logic                  data_q, data_d;
  logic                  underrun_q, underrun_d;

  logic                  tick, fall, load;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [FRAME_W-1:0]    fifo_rdata;
  logic [FRAME_BITS-1:0] fifo_stream;
  logic [BitW-1:0]       lj_idx, i2s_idx;

  audio_frame_fifo #(
    .Width (FRAME_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .push_i  (iVALID),
    .wdata_i (iDATA),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (oFIFO_LEVEL)
  );

  // Stream order: bit FRAME_BITS-1 is slot0 MSB, samples left-aligned in their slots.
  always_comb begin
    fifo_stream = '0;
    for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
      fifo_stream[FRAME_BITS-1-c*SLOT_WIDTH -: DATA_WIDTH] =
          fifo_rdata[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign tick = (div_q == DivW'(BCK_HALF - 1));
  assign fall = tick && bck_q;
  assign load = fall && (bit_q == BitW'(FRAME_BITS - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_q      <= '0;
      bck_q      <= 1'b0;
      bit_q      <= '0;
      frame_q    <= '0;
      mode_q     <= MODE_I2S;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bck_q      <= bck_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      mode_q     <= mode_d;
      lrck_q     <= lrck_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    bck_d      = bck_q ^ tick;
    bit_d      = bit_q;
    frame_d    = frame_q;
    mode_d     = mode_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    if (load) begin
      bit_d      = '0;
      mode_d     = (iMODE == MODE_RSVD) ? MODE_LJ : iMODE;
      fifo_pop   = !fifo_empty;
      underrun_d = fifo_empty;
      if (iMUTE)                      frame_d = '0;
      else if (!fifo_empty)           frame_d = fifo_stream;
      else if (UNDERRUN_REPEAT == 0)  frame_d = '0;
    end else if (fall) begin
      bit_d = bit_q + 1'b1;
    end
  end

  // I2S lags by one bit; at b=0 it still shows the old frame's final bit.
  always_comb begin
    lrck_d  = lrck_q;
    data_d  = data_q;
    lj_idx  = BitW'(FRAME_BITS - 1) - bit_d;
    i2s_idx = lj_idx + 1'b1;
    if (fall) begin
      if (mode_d == MODE_DSP) lrck_d = (bit_d == '0);
      else                    lrck_d = (bit_d >= BitW'(FRAME_BITS / 2));
      if (mode_d == MODE_I2S) data_d = (bit_d == '0) ? frame_q[0] : frame_d[i2s_idx];
      else                    data_d = frame_d[lj_idx];
    end
  end

  assign oAUD_BCK  = bck_q;
  assign oAUD_LRCK = lrck_q;
  assign oAUD_DATA = data_q;
  assign oUNDERRUN = underrun_q;
  assign oREADY    = !fifo_full;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: default stereo instance, an underrun-repeat
// instance and a 4-channel TDM instance, checked against hand-computed frames.
module tb_audio_i2s_tx;

  logic        clk;
  logic        rst0, rst1, rst2;
  logic        valid;
  logic [95:0] din;
  logic [1:0]  mode;
  logic        mute;
  int          sel;

  logic        bck0, lr0, dat0, ur0, rdy0;
  logic        bck1, lr1, dat1, ur1, rdy1;
  logic        bck2, lr2, dat2, ur2, rdy2;
  logic [3:0]  lvl0, lvl1, lvl2;

  logic        o_bck, o_lrck, o_data, o_urun, o_rdy, o_rst;
  logic [3:0]  o_lvl;
  int          fb;

  int          n_checks = 0;
  int          n_errors = 0;

  // Monitor state, updated only by the negedge monitor.
  logic        prev_bck = 1'b0;
  int          bidx = 0;
  int          nfall = 0;
  int          ucnt = 0;

  audio_i2s_tx u_dut (
    .iCLK        (clk),
    .iRST        (rst0),
    .iDATA       (din[31:0]),
    .iVALID      (valid && (sel == 0)),
    .oREADY      (rdy0),
    .iMODE       (mode),
    .iMUTE       (mute),
    .oAUD_BCK    (bck0),
    .oAUD_LRCK   (lr0),
    .oAUD_DATA   (dat0),
    .oUNDERRUN   (ur0),
    .oFIFO_LEVEL (lvl0)
  );

  audio_i2s_tx #(
    .UNDERRUN_REPEAT (1)
  ) u_dut_rep (
    .iCLK        (clk),
    .iRST        (rst1),
    .iDATA       (din[31:0]),
    .iVALID      (valid && (sel == 1)),
    .oREADY      (rdy1),
    .iMODE       (mode),
    .iMUTE       (mute),
    .oAUD_BCK    (bck1),
    .oAUD_LRCK   (lr1),
    .oAUD_DATA   (dat1),
    .oUNDERRUN   (ur1),
    .oFIFO_LEVEL (lvl1)
  );

  audio_i2s_tx #(
    .REF_CLK     (24576000),
    .DATA_WIDTH  (24),
    .SLOT_WIDTH  (32),
    .CHANNEL_NUM (4)
  ) u_dut_tdm (
    .iCLK        (clk),
    .iRST        (rst2),
    .iDATA       (din),
    .iVALID      (valid && (sel == 2)),
    .oREADY      (rdy2),
    .iMODE       (mode),
    .iMUTE       (mute),
    .oAUD_BCK    (bck2),
    .oAUD_LRCK   (lr2),
    .oAUD_DATA   (dat2),
    .oUNDERRUN   (ur2),
    .oFIFO_LEVEL (lvl2)
  );

  assign o_bck  = (sel == 0) ? bck0 : (sel == 1) ? bck1 : bck2;
  assign o_lrck = (sel == 0) ? lr0  : (sel == 1) ? lr1  : lr2;
  assign o_data = (sel == 0) ? dat0 : (sel == 1) ? dat1 : dat2;
  assign o_urun = (sel == 0) ? ur0  : (sel == 1) ? ur1  : ur2;
  assign o_rdy  = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  assign o_lvl  = (sel == 0) ? lvl0 : (sel == 1) ? lvl1 : lvl2;
  assign o_rst  = (sel == 0) ? rst0 : (sel == 1) ? rst1 : rst2;
  assign fb     = (sel == 2) ? 128 : 32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_bck <= o_bck;
    if (prev_bck && !o_bck) begin
      nfall <= nfall + 1;
      bidx  <= (bidx == fb - 1) ? 0 : bidx + 1;
    end
    if (o_urun) ucnt <= ucnt + 1;
    if (o_rst) begin
      prev_bck <= 1'b0;
      bidx     <= 0;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fall();
    int start;
    start = nfall;
    for (int i = 0; i < 200; i++) begin
      step();
      if (nfall != start) return;
    end
    check("fall_timeout", 1'b0, 1'b1);
  endtask

  task automatic sync_frame();
    int guard;
    guard = 0;
    do begin
      wait_fall();
      guard++;
    end while (bidx != 0 && guard < 200);
  endtask

  task automatic capture(output logic [127:0] dw, output logic [127:0] lw);
    dw = '0;
    lw = '0;
    sync_frame();
    for (int b = 0; b < fb; b++) begin
      if (b != 0) wait_fall();
      dw[fb-1-b] = o_data;
      lw[fb-1-b] = o_lrck;
    end
  endtask

  task automatic push(input logic [95:0] d);
    din   = d;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  function automatic logic pick(input int which);
    if (which == 0) return o_bck;
    if (which == 1) return o_lrck;
    return o_urun;
  endfunction

  // Measures high time and period (in clocks) of a selected output.
  task automatic measure(input int which, output int hi, output int per);
    int   phase;
    int   cnt;
    logic prev, cur;
    phase = 0;
    cnt   = 0;
    hi    = 0;
    per   = 0;
    prev  = pick(which);
    for (int n = 0; n < 2000 && phase < 2; n++) begin
      step();
      cur = pick(which);
      if (phase == 1) cnt++;
      if (!prev && cur) begin
        if (phase == 1) begin
          per   = cnt;
          phase = 2;
        end else begin
          phase = 1;
          cnt   = 0;
        end
      end else if (prev && !cur && phase == 1) begin
        hi = cnt;
      end
      prev = cur;
    end
  endtask

  task automatic do_reset(input int which);
    sel   = which;
    valid = 1'b1;  // pushes during reset must be dropped
    din   = 96'hDEAD;
    if (which == 0) rst0 = 1'b1;
    else if (which == 1) rst1 = 1'b1;
    else rst2 = 1'b1;
    step();
    step();
    check("rst_bck", o_bck, 1'b0);
    check("rst_lrck", o_lrck, 1'b0);
    check("rst_data", o_data, 1'b0);
    check("rst_urun", o_urun, 1'b0);
    check("rst_level", o_lvl, 4'd0);
    check("rst_ready", o_rdy, 1'b1);
    valid = 1'b0;
    rst0  = 1'b0;
    rst1  = 1'b0;
    rst2  = 1'b0;
    step();
    check("rst_nopush", o_lvl, 4'd0);
  endtask

  logic [127:0] dw, lw;
  int           hi, per, u0;

  initial begin
    rst0  = 1'b1;
    rst1  = 1'b1;
    rst2  = 1'b1;
    valid = 1'b0;
    din   = '0;
    mode  = 2'd1;
    mute  = 1'b0;
    sel   = 0;
    step();

    // Idle timing, left-justified, no pushes.
    do_reset(0);
    measure(0, hi, per);
    check("bck_high", hi, 6);
    check("bck_period", per, 12);
    measure(1, hi, per);
    check("lrck_high", hi, 192);
    check("lrck_period", per, 384);
    measure(2, hi, per);
    check("urun_width", hi, 1);
    check("urun_period", per, 384);
    capture(dw, lw);
    check("idle_data", dw[31:0], 32'h0);
    check("idle_lrck", lw[31:0], 32'h0000FFFF);

    // Left-justified frame.
    sync_frame();
    push({64'h0, 16'h7FFE, 16'h8001});
    check("lj_level", o_lvl, 4'd1);
    u0 = ucnt;
    capture(dw, lw);
    check("lj_data", dw[31:0], 32'h80017FFE);
    check("lj_lrck", lw[31:0], 32'h0000FFFF);
    check("lj_no_urun", ucnt - u0, 0);
    check("lj_level_pop", o_lvl, 4'd0);

    // I2S: one-bit lag, previous frame's last bit at b=0.
    sync_frame();
    mode = 2'd0;
    push({64'h0, 16'h7FFE, 16'h8001});
    push({64'h0, 16'h0001, 16'h0000});
    push(96'h0);
    capture(dw, lw);
    check("i2s_a_data", dw[31:0], 32'h4000BFFF);
    check("i2s_a_lrck", lw[31:0], 32'h0000FFFF);
    capture(dw, lw);
    check("i2s_b_data", dw[31:0], 32'h00000000);
    capture(dw, lw);
    check("i2s_c_data", dw[31:0], 32'h80000000);

    // Reserved mode behaves as left-justified.
    sync_frame();
    mode = 2'd3;
    push({64'h0, 16'h7FFE, 16'h8001});
    capture(dw, lw);
    check("rsvd_data", dw[31:0], 32'h80017FFE);

    // FIFO fill: 9 pushes, 8 accepted, drained in order.
    mode = 2'd1;
    do_reset(0);
    for (int k = 1; k <= 9; k++) begin
      push({64'h0, 16'hA000 + 16'(k), 16'h0100 + 16'(k)});
      if (k == 7) check("ready_7", o_rdy, 1'b1);
      if (k == 8) check("ready_8", o_rdy, 1'b0);
    end
    check("full_level", o_lvl, 4'd8);
    for (int k = 1; k <= 8; k++) begin
      capture(dw, lw);
      check($sformatf("order_%0d", k), dw[31:0], {16'h0100 + 16'(k), 16'hA000 + 16'(k)});
      if (k == 1) check("ready_after_pop", o_rdy, 1'b1);
    end
    capture(dw, lw);
    check("ninth_dropped", dw[31:0], 32'h0);

    // Underrun repeat and mute.
    mode = 2'd1;
    do_reset(1);
    push({64'h0, 16'h5678, 16'h1234});
    u0 = ucnt;
    capture(dw, lw);
    check("rep_first", dw[31:0], 32'h12345678);
    check("rep_first_urun", ucnt - u0, 0);
    for (int k = 0; k < 2; k++) begin
      u0 = ucnt;
      capture(dw, lw);
      check("rep_data", dw[31:0], 32'h12345678);
      check("rep_urun", ucnt - u0, 1);
    end
    mute = 1'b1;
    push({64'h0, 16'h2222, 16'h1111});
    push({64'h0, 16'h4444, 16'h3333});
    check("mute_level2", o_lvl, 4'd2);
    u0 = ucnt;
    capture(dw, lw);
    check("mute_data1", dw[31:0], 32'h0);
    check("mute_level1", o_lvl, 4'd1);
    check("mute_no_urun", ucnt - u0, 0);
    capture(dw, lw);
    check("mute_data2", dw[31:0], 32'h0);
    check("mute_level0", o_lvl, 4'd0);
    mute = 1'b0;

    // 4-channel TDM, 24-bit samples in 32-bit slots.
    mode = 2'd2;
    do_reset(2);
    measure(0, hi, per);
    check("tdm_bck_period", per, 4);
    push({24'h000003, 24'h000002, 24'h000001, 24'hABCDEF});
    capture(dw, lw);
    check("tdm_data", dw, {32'hABCDEF00, 32'h00000100, 32'h00000200, 32'h00000300});
    check("tdm_lrck", lw, {1'b1, 127'h0});
    measure(1, hi, per);
    check("tdm_lrck_high", hi, 4);
    check("tdm_lrck_period", per, 512);

    // Asynchronous reset in the middle of a frame.
    push({24'h000003, 24'h000002, 24'h000001, 24'hABCDEF});
    push({24'h000003, 24'h000002, 24'h000001, 24'hABCDEF});
    sync_frame();
    wait_fall();
    wait_fall();
    check("mid_level", o_lvl, 4'd1);
    check("mid_data", o_data, 1'b1);
    #2;
    rst2 = 1'b1;
    #1;
    check("abort_data", o_data, 1'b0);
    check("abort_lrck", o_lrck, 1'b0);
    check("abort_bck", o_bck, 1'b0);
    check("abort_level", o_lvl, 4'd0);
    check("abort_ready", o_rdy, 1'b1);
    step();
    rst2 = 1'b0;
    capture(dw, lw);
    check("abort_silence", dw, 128'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
Parametrised audio serial transmitter that replaces the fixed 16-bit stereo DAC driver.
- Accepts whole multi-channel frames on a valid/ready stream into an internal frame FIFO.
- Serialises frames MSB-first in I2S, left-justified or DSP/TDM format.
- Generates BCK and LRCK from the single system clock using clock-enable logic, with no derived clock domains.
- Sits between the audio mixer/source logic and the board codec pins.

Parameters:
- REF_CLK, 18432000, system clock frequency in Hz.
- SAMPLE_RATE, 48000, frame rate in Hz.
- DATA_WIDTH, 16, sample bits per channel, 8..32.
- SLOT_WIDTH, 16, bits per channel slot on the wire; must be >= DATA_WIDTH.
- CHANNEL_NUM, 2, channels per frame: 2, 4 or 8.
- FIFO_DEPTH, 8, frames of buffering; power of 2, >= 2.
- UNDERRUN_REPEAT, 0, on underrun: 0 sends zeros, 1 repeats the last frame.

Ports:
- iCLK  input  1  system clock; all logic runs on its rising edge.
- iRST  input  1  asynchronous, active-high reset.
- iDATA  input  DATA_WIDTH*CHANNEL_NUM  frame; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH], two's complement.
- iVALID  input  1  frame valid.
- oREADY  output  1  FIFO not full.
- iMODE  input  2  0 = I2S, 1 = left-justified, 2 = DSP/TDM, 3 = reserved (treated as 1).
- iMUTE  input  1  send zeros.
- oAUD_BCK  output  1  bit clock.
- oAUD_LRCK  output  1  frame/word clock.
- oAUD_DATA  output  1  serial data.
- oUNDERRUN  output  1  one-clock pulse on an empty-FIFO frame load.
- oFIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  frames currently stored.

Behaviour:
Derived constants
- FRAME_BITS = CHANNEL_NUM*SLOT_WIDTH.
- BCK_HALF = REF_CLK/(SAMPLE_RATE*FRAME_BITS*2). Must be an exact integer >= 1; elaboration fails otherwise. Defaults give 6.

Reset values
- oAUD_BCK = 0, oAUD_LRCK = 0, oAUD_DATA = 0, oUNDERRUN = 0.
- oFIFO_LEVEL = 0, oREADY = 1.
- Bit index b = 0, frame register = 0, latched mode = 0.
- Pushes while iRST is high are ignored.
- Reset mid-frame aborts the frame immediately and empties the FIFO.

BCK generation
- Divider counts 0..BCK_HALF-1; oAUD_BCK toggles on the terminal count.
- A falling event is the clock on which BCK goes 1->0.
- On each falling event b advances modulo FRAME_BITS. oAUD_LRCK and oAUD_DATA change only on falling events.

Frame load
- Occurs on the falling event where b wraps FRAME_BITS-1 -> 0.
- iMODE and iMUTE are sampled at the load; mode never changes mid-frame.
- The FIFO is popped if non-empty, even when muted.
- If the FIFO is empty: oUNDERRUN pulses for that clock, and the frame is zeros (or the previous frame when UNDERRUN_REPEAT=1).
- If muted, the frame register is loaded with zeros.
- Each slot holds its sample in the top DATA_WIDTH bits, zero-padded in the low SLOT_WIDTH-DATA_WIDTH bits.
- Stream S = slot0 MSB .. slot(N-1) LSB.
- The first frame after reset is silence. A frame pushed at least one clock before a load is output from that load.

Output timing per latched mode
- Left-justified:
  - oAUD_DATA = S[b].
  - oAUD_LRCK = 0 for b < FRAME_BITS/2, 1 otherwise.
- I2S:
  - LRCK identical to left-justified.
  - oAUD_DATA = S[b-1]; at b = 0 it carries the LSB of the previous frame's last slot.
- DSP/TDM:
  - oAUD_DATA = S[b].
  - oAUD_LRCK = 1 only while b = 0.

FIFO
- A push happens when iVALID && oREADY. Frames pop in order.
- oREADY = level != FIFO_DEPTH, registered.
- Push and pop on the same clock leave the level unchanged.
- A push into an empty FIFO on the load clock is not visible to that load: the load underruns and the frame is kept for the next load.

Decomposition:
- Package audio_pkg: mode encodings (MODE_I2S, MODE_LJ, MODE_DSP) and a constant function for BCK_HALF plus its integer-ratio check.
- One sub-module, audio_frame_fifo: synchronous FIFO parametrised by width and depth, with push, pop, level, full and empty.
- BCK/LRCK timing and the serialiser stay in audio_i2s_tx.

Test Plan:
1. Defaults, left-justified, no pushes -> BCK period 12 clocks; LRCK period 384 clocks, 192 low / 192 high; data all 0; oUNDERRUN pulses every 384 clocks.
2. Left-justified, push L=0x8001, R=0x7FFE -> next frame bits 1000000000000001 with LRCK=0, then 0111111111111110 with LRCK=1.
3. Same frame followed by a zero frame in I2S mode -> serial stream delayed by one BCK; bit at b=0 of the following frame = 0 (LSB of 0x7FFE); frame carries 0x8001 MSB at b=1.
4. UNDERRUN_REPEAT=1: push one frame 0x1234/0x5678, then stop -> every subsequent frame repeats 0x1234/0x5678; oUNDERRUN pulses at each load. iMUTE=1 -> zeros while the FIFO still drains.
5. Push 9 frames back-to-back with no load -> oREADY low after the 8th; 9th ignored; oFIFO_LEVEL = 8; frames output in order 1..8.
6. REF_CLK=24576000, CHANNEL_NUM=4, SLOT_WIDTH=32, DATA_WIDTH=24, DSP mode, channels 0xABCDEF, 1, 2, 3 -> BCK_HALF=2; 128 bits/frame; LRCK high for exactly one BCK at b=0; slot0 = 0xABCDEF00; assert iRST mid-frame -> all outputs 0 and oFIFO_LEVEL=0 on the same clock.
